// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with a registered broadcast stage
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*tag_width-1:0]  req_tag,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          cdb_valid,
  output logic [tag_width-1:0]          cdb_tag,
  output logic [data_width-1:0]         cdb_data,
  output logic [15:0]                   bcast_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  logic             issue;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign issue    = found && !reset && !flush;
  assign next_ptr = PTR_W'((int'(sel) + 1) % NUM_REQ);

  always_comb begin
    grant = '0;
    if (issue) begin
      grant[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      rr_ptr      <= '0;
      bcast_count <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (issue) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= req_tag[int'(sel)*tag_width +: tag_width];
      cdb_data  <= req_data[int'(sel)*data_width +: data_width];
      rr_ptr    <= next_ptr;
      if (bcast_count != 16'hFFFF) begin
        bcast_count <= bcast_count + 16'd1;
      end
    end else begin
      // Tag and data hold; they are don't-care while cdb_valid is low.
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a reference model
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [15:0]     bcast_count;

  cdb_arbiter #(.NUM_REQ(N), .data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            m_ptr    = 0;
  int            m_cnt    = 0;
  logic          m_valid  = 1'b0;
  logic [TW-1:0] m_tag    = '0;
  logic [DW-1:0] m_data   = '0;
  logic [TW-1:0] tg[N];
  logic [DW-1:0] dt[N];
  int            last_g   = -1;
  logic [N-1:0]  pend;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Highest priority is the pointer position; walk forward with wrap.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic rst, input logic fl, input logic [N-1:0] v);
    int g;
    logic [N-1:0] eg;
    reset     = rst;
    flush     = fl;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tg[i];
      req_data[i*DW +: DW] = dt[i];
    end
    #1;
    g  = (rst || fl) ? -1 : pick(v, m_ptr);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_tag = '0; m_data = '0; m_ptr = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 1'b0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_tag = tg[g]; m_data = dt[g]; m_ptr = (g + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_valid = 1'b0;
    end
    check("cdb_valid", 32'(cdb_valid), 32'(m_valid));
    check("cdb_tag", 32'(cdb_tag), 32'(m_tag));
    check("cdb_data", 32'(cdb_data), 32'(m_data));
    check("bcast_count", 32'(bcast_count), 32'(m_cnt));
    last_g = g;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 1);
      dt[i] = DW'(16'hA000 + i);
    end
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b0, 4'b1111);
    check("reset_valid", 32'(cdb_valid), 32'd0);

    // Single requester 1
    tg[1] = 3'd5; dt[1] = 16'h1234;
    cycle(1'b0, 1'b0, 4'b0010);
    check("t1_tag", 32'(cdb_tag), 32'd5);
    check("t1_data", 32'(cdb_data), 32'h1234);
    check("t1_count", 32'(bcast_count), 32'd1);
    cycle(1'b0, 1'b0, 4'b0000);

    // Flush with all valid, then full rotation from pointer 0
    for (int i = 0; i < N; i++) tg[i] = TW'(i + 1);
    cycle(1'b0, 1'b1, 4'b1111);
    check("flush_valid", 32'(cdb_valid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0, 4'b1111);
      check("rot_tag", 32'(cdb_tag), 32'((c % N) + 1));
    end

    // Pointer to 3, then wrap with 0101
    cycle(1'b0, 1'b0, 4'b0100);
    cycle(1'b0, 1'b0, 4'b0101);
    check("wrap_tag", 32'(cdb_tag), 32'(tg[0]));
    cycle(1'b0, 1'b0, 4'b0101);
    check("wrap2_tag", 32'(cdb_tag), 32'(tg[2]));

    // Reset while requester 2 would win
    cycle(1'b0, 1'b0, 4'b0001);
    cycle(1'b1, 1'b0, 4'b0100);
    check("rst_mid_count", 32'(bcast_count), 32'd0);

    // Randomized traffic honouring the requester handshake
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      logic fl;
      logic rst;
      fl  = ($urandom_range(15) == 0);
      rst = ($urandom_range(63) == 0);
      cycle(rst, fl, pend);
      if (rst || fl) begin
        pend = '0;
      end else if (last_g >= 0) begin
        pend[last_g] = 1'($urandom_range(1));
        tg[last_g]   = TW'($urandom);
        dt[last_g]   = DW'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          tg[i]   = TW'($urandom);
          dt[i]   = DW'($urandom);
        end
      end
    end

    // Saturation of the broadcast counter
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (65538) cycle(1'b0, 1'b0, 4'b1111);
    check("sat_count", 32'(bcast_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus among the functional units that complete results: the three ALU reservation-station slots and the load buffer.
- Grants one requester per cycle using round-robin priority. Registers the winner's tag and data and broadcasts them on the CDB one cycle later.
- The CDB output is the bus consumed by issue control, the reservation stations, the ROB and the regfile.

Parameters:
- NUM_REQ, 4, number of requesters. Index 0..2 are ALU stations 1..3; index 3 is the load buffer.
- data_width, 16, result data width.
- tag_width, 3, ROB-entry tag width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush (mispredict or exception): squashes arbitration this cycle.
- req_valid  input  NUM_REQ  bit i set = requester i holds a completed result.
- req_tag  input  NUM_REQ*tag_width  packed tags; requester i occupies bits [i*tag_width +: tag_width].
- req_data  input  NUM_REQ*data_width  packed results; requester i occupies bits [i*data_width +: data_width].
- grant  output  NUM_REQ  one-hot, combinational; bit i means requester i's result is captured at this edge.
- cdb_valid  output  1  registered; the CDB carries a valid broadcast this cycle.
- cdb_tag  output  tag_width  registered ROB tag of the broadcast.
- cdb_data  output  data_width  registered broadcast data.
- bcast_count  output  16  saturating count of broadcasts since reset.

Behaviour:
- Reset (sync, active-high): at the next edge, cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0, bcast_count=0. While reset=1, grant=0.
- Internal state rr_ptr ranges over 0..NUM_REQ-1 and names the highest-priority requester.
- Grant (combinational):
  - If reset=0 and flush=0, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - At most one grant bit is set. If req_valid=0, grant=0.
- Capture at the edge:
  - If a grant is issued: cdb_valid<=1, cdb_tag<=req_tag[g], cdb_data<=req_data[g], rr_ptr<=(g+1) mod NUM_REQ.
  - Otherwise: cdb_valid<=0 and cdb_tag/cdb_data hold their old values (don't-care when invalid). rr_ptr is unchanged.
- Latency: exactly 1 cycle from grant to cdb_valid. Back-to-back broadcasts are allowed every cycle.
- Requester handshake:
  - Requester i holds req_valid/tag/data stable until it sees grant[i]=1.
  - It must deassert or present a new result in the following cycle.
  - A request that is not granted is not lost; the requester keeps asserting it.
- Fairness: with all NUM_REQ requesting continuously, each is granted once every NUM_REQ cycles. No requester waits more than NUM_REQ-1 cycles after first asserting.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Flush:
  - When flush=1: grant=0, cdb_valid<=0 at the edge, rr_ptr<=0.
  - Any broadcast already on the CDB in the flush cycle (registered earlier) still appears that cycle.
  - Requesters are expected to clear their own req_valid on flush.
- Priority of controls: reset over flush over normal arbitration.
- bcast_count increments on each edge where a grant is issued and saturates at 16'hFFFF.
- Reset mid-burst: the pending grant is dropped and the CDB goes invalid the next cycle. Requesters re-request after reset.

Test Plan:
1. Reset, then req_valid=4'b0010, tag1=3'd5, data1=16'h1234. Required: grant=4'b0010 that cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'h1234; rr_ptr=2; bcast_count=1.
2. All four requesters held valid with distinct tags 1..4, starting from rr_ptr=0. Required: grants cycle 0001, 0010, 0100, 1000, 0001…; CDB tags follow 1,2,3,4,1 each one cycle later.
3. rr_ptr=3, req_valid=4'b0101. Required: grant=4'b0001 (wrap); rr_ptr becomes 1; the next cycle with the same request gives grant=4'b0100.
4. Flush asserted while req_valid=4'b1111. Required: grant=0; next cycle cdb_valid=0; rr_ptr=0. The following cycle (no flush, all valid) gives grant=4'b0001.
5. Reset asserted during the cycle in which requester 2 is granted. Required: grant=0 that cycle; next cycle cdb_valid=0, cdb_tag=0, cdb_data=0, bcast_count=0.
6. Preload bcast_count near saturation via 65535 broadcasts, then 3 more. Required: bcast_count stays 16'hFFFF.
